// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: AXI4-Stream UART transmitter with an input FIFO,
// runtime parity, one or two stop bits and line-break generation.
module uart_tx_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic                     txd,
    output logic                     busy,
    output logic [FIFO_ADDR_WIDTH:0] fifo_count,
    input  logic [15:0]              prescale,
    input  logic [1:0]               parity_mode,
    input  logic                     two_stop,
    input  logic                     send_break
);
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int BW    = $clog2(DATA_WIDTH);
    localparam logic [FIFO_ADDR_WIDTH:0] FULL = (FIFO_ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK, MARK
    } state_t;

    state_t                     state;
    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0]      shreg;
    logic [BW-1:0]              bit_cnt;
    logic [18:0]                timer;
    logic [18:0]                bit_len;
    logic                       par_en;
    logic                       par_bit;
    logic                       stop2;
    logic                       stop_left;

    logic [15:0]           ps_eff;
    logic [18:0]           len_now;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_en;
    logic                  timer_done;
    logic                  frame_end;
    logic                  launch;
    logic                  go_break;
    logic                  go_start;

    assign ps_eff        = (prescale == 16'd0) ? 16'd1 : prescale;
    assign len_now       = {ps_eff, 3'b000} - 19'd1;
    assign head          = mem[rd_ptr];
    assign s_axis_tready = (fifo_count != FULL);
    assign busy          = (state != IDLE) || (fifo_count != '0);
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign timer_done    = (timer == '0);

    // Frames and breaks chain directly from the last period, so
    // queued words follow with no idle cycle in between.
    assign frame_end = timer_done &&
                       ((state == STOP && !stop_left) || state == MARK);
    assign launch    = (state == IDLE) || frame_end;
    assign go_break  = launch && send_break;
    assign go_start  = launch && !send_break && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            txd        <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            timer      <= '0;
            bit_len    <= '0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            stop2      <= 1'b0;
            stop_left  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (go_start) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, go_start})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase

            unique case (1'b1)
                go_break: begin
                    state   <= BREAK;
                    txd     <= 1'b0;
                    timer   <= len_now;
                    bit_len <= len_now;
                end
                go_start: begin
                    state   <= START;
                    txd     <= 1'b0;
                    timer   <= len_now;
                    bit_len <= len_now;
                    shreg   <= head;
                    par_en  <= parity_mode[0] ^ parity_mode[1];
                    par_bit <= (^head) ^ (parity_mode == 2'b10);
                    stop2   <= two_stop;
                end
                default: begin
                    if (state != IDLE) begin
                        if (!timer_done) begin
                            timer <= timer - 19'd1;
                        end else begin
                            timer <= bit_len;
                            unique case (state)
                                START: begin
                                    txd     <= shreg[0];
                                    shreg   <= shreg >> 1;
                                    bit_cnt <= BW'(DATA_WIDTH-1);
                                    state   <= DATA;
                                end
                                DATA: begin
                                    if (bit_cnt != '0) begin
                                        txd     <= shreg[0];
                                        shreg   <= shreg >> 1;
                                        bit_cnt <= bit_cnt - 1'b1;
                                    end else if (par_en) begin
                                        txd   <= par_bit;
                                        state <= PARITY;
                                    end else begin
                                        txd       <= 1'b1;
                                        stop_left <= stop2;
                                        state     <= STOP;
                                    end
                                end
                                PARITY: begin
                                    txd       <= 1'b1;
                                    stop_left <= stop2;
                                    state     <= STOP;
                                end
                                STOP: begin
                                    if (stop_left) begin
                                        stop_left <= 1'b0;
                                    end else begin
                                        state <= IDLE;
                                    end
                                end
                                BREAK: begin
                                    if (!send_break) begin
                                        txd   <= 1'b1;
                                        state <= MARK;
                                    end
                                end
                                MARK:    state <= IDLE;
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule
